mx_stream_feeder: RTL and testbench

//  Upstream stage of MM. Fetches one job (three ragged-row 8-bit matrices) from a byte-wide

---
 rtl/mx_stream_feeder_pkg.sv | 30 +++
 rtl/mx_stream_feeder_skid_fifo.sv | 64 ++++++
 rtl/mx_stream_feeder.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_mx_stream_feeder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mx_stream_feeder_pkg.sv
// Shared types and constants for the matrix stream feeder.
// Covers FSM state encoding, shape limits and the element record carried through the skid FIFO.
package mx_stream_feeder_pkg;

    localparam int SHP_W   = 4;
    localparam int MAX_DIM = 15;
    localparam int N_MX    = 3;
    localparam int TAB_D   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_R  = 3'd1,
        ST_HDR_C  = 3'd2,
        ST_STREAM = 3'd3,
        ST_GAP    = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       col_end;
        logic       row_end;
    } elem_t;

    // A shape byte is legal only in the range 1..MAX_DIM.
    function automatic logic shape_bad(input logic [7:0] b);
        return (b == 8'd0) || (b > 8'(MAX_DIM));
    endfunction

endpackage

// File: rtl/mx_stream_feeder_skid_fifo.sv
// Two-entry skid FIFO (module mx_skid_fifo) holding prefetched elements.
// Push while full is accepted only when a pop happens in the same cycle.
module mx_skid_fifo #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wp_q;
    logic         rp_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         do_pop_s;
    logic         do_push_s;

    assign full_o    = (cnt_q == 2'd2);
    assign empty_o   = (cnt_q == 2'd0);
    assign rdata_o   = mem_q[rp_q];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Occupancy update from the effective push/pop pair.
    always_comb begin
        cnt_d = cnt_q;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (clr_i) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wp_q] <= wdata_i;
                wp_q        <= ~wp_q;
            end
            if (do_pop_s) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mx_stream_feeder.sv
// Fetches a three-matrix job from byte memory and replays it as an element stream.
// Optional FEED_CHECKSUM_EN adds a 16-bit sum of accepted elements on port csum.
module mx_stream_feeder
    import mx_stream_feeder_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    input  logic          busy,
    output logic          feed_vld,
    output logic [7:0]    in_data,
    output logic          col_end,
    output logic          row_end,
    output logic          done,
    output logic          err
`ifdef FEED_CHECKSUM_EN
    ,
    output logic [15:0]   csum
`endif
);

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic             mem_rd_q, mem_rd_d;
    logic             rdv_q;
    logic             hdr_pend_q, hdr_pend_d;
    logic [SHP_W-1:0] rows_q, rows_d;
    logic [SHP_W-1:0] hc_q, hc_d;
    logic [7:0]       total_q, total_d;
    logic [7:0]       issued_q, issued_d;
    logic [SHP_W-1:0] arr_r_q, arr_r_d;
    logic [SHP_W-1:0] arr_c_q, arr_c_d;
    logic [1:0]       mx_q, mx_d;
    logic [1:0]       gap_q, gap_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [SHP_W-1:0] shape_q [TAB_D];

    logic             out_vld_q, out_vld_d;
    elem_t            out_q, out_d;

    logic             issue_s;
    logic             tab_we_s;
    logic             start_acc_s;
    logic             accept_s;
    logic             slot_free_s;
    logic             rdv_stream_s;
    logic             arr_ce_s;
    logic             arr_re_s;
    elem_t            arr_elem_s;
    logic             push_s;
    logic             pop_s;
    logic             byp_s;
    elem_t            fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [2:0]       fifo_occ_s;
    logic [2:0]       commit_s;
    logic             room_s;

    assign start_acc_s  = (state_q == ST_IDLE) && start;
    assign accept_s     = out_vld_q && !busy;
    assign slot_free_s  = !out_vld_q || accept_s;
    assign rdv_stream_s = rdv_q && (state_q == ST_STREAM);
    assign arr_ce_s     = (arr_c_q == (shape_q[arr_r_q] - 4'd1));
    assign arr_re_s     = arr_ce_s && (arr_r_q == (rows_q - 4'd1));
    assign arr_elem_s   = '{data: mem_rdata, col_end: arr_ce_s, row_end: arr_re_s};

    assign pop_s  = slot_free_s && !fifo_empty_s;
    assign byp_s  = slot_free_s && fifo_empty_s && rdv_stream_s;
    assign push_s = rdv_stream_s && !byp_s;

    // Output register, FIFO and reads in flight together hold at most three elements.
    assign fifo_occ_s = fifo_full_s ? 3'd2 : (fifo_empty_s ? 3'd0 : 3'd1);
    assign commit_s   = 3'(out_vld_q) + fifo_occ_s + 3'(rdv_q) + 3'(mem_rd_q);
    assign room_s     = (commit_s + 3'd1) <= (3'd3 + 3'(accept_s));

    mx_skid_fifo #(.W($bits(elem_t))) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (start_acc_s),
        .push_i  (push_s),
        .wdata_i (arr_elem_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Sequencer: header parsing, element fetch issue and job completion.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        hdr_pend_d = hdr_pend_q;
        rows_d     = rows_q;
        hc_d       = hc_q;
        total_d    = total_q;
        issued_d   = issued_q;
        arr_r_d    = arr_r_q;
        arr_c_d    = arr_c_q;
        mx_d       = mx_q;
        gap_d      = gap_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tab_we_s   = 1'b0;
        issue_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_HDR_R;
                    addr_d     = base_addr;
                    mx_d       = 2'd0;
                    hdr_pend_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR_R: begin
                if (rdv_q) begin
                    hdr_pend_d = 1'b0;
                    if (shape_bad(mem_rdata)) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        rows_d  = mem_rdata[SHP_W-1:0];
                        hc_d    = '0;
                        total_d = 8'd0;
                        state_d = ST_HDR_C;
                    end
                end else if (!hdr_pend_q) begin
                    issue_s    = 1'b1;
                    hdr_pend_d = 1'b1;
                end else begin
                    hdr_pend_d = hdr_pend_q;
                end
            end
            ST_HDR_C: begin
                if (rdv_q) begin
                    hdr_pend_d = 1'b0;
                    if (shape_bad(mem_rdata)) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        tab_we_s = 1'b1;
                        total_d  = total_q + 8'(mem_rdata[SHP_W-1:0]);
                        if (hc_q == (rows_q - 4'd1)) begin
                            // First element read goes out with the state change.
                            state_d  = ST_STREAM;
                            issue_s  = 1'b1;
                            issued_d = 8'd1;
                            arr_r_d  = '0;
                            arr_c_d  = '0;
                        end else begin
                            hc_d = hc_q + 4'd1;
                        end
                    end
                end else if (!hdr_pend_q) begin
                    issue_s    = 1'b1;
                    hdr_pend_d = 1'b1;
                end else begin
                    hdr_pend_d = hdr_pend_q;
                end
            end
            ST_STREAM: begin
                if ((issued_q != total_q) && room_s) begin
                    issue_s  = 1'b1;
                    issued_d = issued_q + 8'd1;
                end else begin
                    issued_d = issued_q;
                end
                if (accept_s && out_q.row_end) begin
                    if (mx_q == 2'(N_MX - 1)) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        mx_d    = mx_q + 2'd1;
                        gap_d   = 2'd0;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_GAP: begin
                if ((gap_q == 2'd1) && !busy) begin
                    state_d    = ST_HDR_R;
                    hdr_pend_d = 1'b0;
                end else if (gap_q != 2'd1) begin
                    gap_d = gap_q + 2'd1;
                end else begin
                    gap_d = gap_q;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rdv_stream_s) begin
            if (arr_ce_s) begin
                arr_c_d = '0;
                arr_r_d = arr_r_q + 4'd1;
            end else begin
                arr_c_d = arr_c_q + 4'd1;
            end
        end else begin
            arr_c_d = arr_c_d;
        end

        if (issue_s) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_q;
            addr_d     = addr_q + AW'(1);
        end else begin
            mem_rd_d = 1'b0;
        end
    end

    // Output stage: refill from FIFO head first, else straight from memory.
    always_comb begin
        out_vld_d = out_vld_q;
        out_d     = out_q;
        if (pop_s) begin
            out_vld_d = 1'b1;
            out_d     = fifo_head_s;
        end else if (byp_s) begin
            out_vld_d = 1'b1;
            out_d     = arr_elem_s;
        end else if (accept_s) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // Control and datapath state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            rdv_q      <= 1'b0;
            hdr_pend_q <= 1'b0;
            rows_q     <= '0;
            hc_q       <= '0;
            total_q    <= 8'd0;
            issued_q   <= 8'd0;
            arr_r_q    <= '0;
            arr_c_q    <= '0;
            mx_q       <= 2'd0;
            gap_q      <= 2'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            rdv_q      <= mem_rd_q;
            hdr_pend_q <= hdr_pend_d;
            rows_q     <= rows_d;
            hc_q       <= hc_d;
            total_q    <= total_d;
            issued_q   <= issued_d;
            arr_r_q    <= arr_r_d;
            arr_c_q    <= arr_c_d;
            mx_q       <= mx_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            err_q      <= err_d;
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
        end
    end

    // Per-row column-count table, filled while parsing the header.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAB_D; i++) shape_q[i] <= '0;
        end else if (tab_we_s) begin
            shape_q[hc_q] <= mem_rdata[SHP_W-1:0];
        end
    end

`ifdef FEED_CHECKSUM_EN
    logic [15:0] csum_q;

    // Running sum of accepted elements, cleared when a job starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 16'd0;
        end else if (start_acc_s) begin
            csum_q <= 16'd0;
        end else if (accept_s) begin
            csum_q <= csum_q + 16'(out_q.data);
        end
    end

    assign csum = csum_q;
`endif

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign feed_vld = out_vld_q;
    assign in_data  = out_q.data;
    assign col_end  = out_q.col_end;
    assign row_end  = out_q.row_end;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mx_stream_feeder.sv
// Directed bench for mx_stream_feeder: stream order/markers, stalls, header abort, reset, wrap.
module tb_mx_stream_feeder;

    typedef struct packed {
        logic [7:0] d;
        logic       ce;
        logic       re;
    } el_t;

    typedef struct {
        logic [7:0] d;
        logic       ce;
        logic       re;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        feed_vld;
    logic [7:0]  in_data;
    logic        col_end;
    logic        row_end;
    logic        done;
    logic        err;
`ifdef FEED_CHECKSUM_EN
    logic [15:0] csum;
`endif

    logic [7:0]  mem [0:65535];
    logic [15:0] wp;
    el_t         got_q[$];
    el_t         exp_q[$];
    int          done_cnt = 0;
    logic        last_err = 1'b0;
    int          fifo_max = 0;
    int          total = 0;
    int          bad = 0;

    mx_stream_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .feed_vld  (feed_vld),
        .in_data   (in_data),
        .col_end   (col_end),
        .row_end   (row_end),
        .done      (done),
        .err       (err)
`ifdef FEED_CHECKSUM_EN
        ,
        .csum      (csum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (feed_vld && !busy) got_q.push_back({in_data, col_end, row_end});
            if (done) begin
                done_cnt++;
                last_err = err;
            end
            if (int'(dut.u_fifo.cnt_q) > fifo_max) fifo_max = int'(dut.u_fifo.cnt_q);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 16'd1;
    endtask

    task automatic put_mx(input int r, input logic [59:0] cs, input logic [7:0] v0, input int step);
        logic [7:0] v;
        el_t        e;
        int         c;
        put_byte(8'(r));
        for (int i = 0; i < r; i++) put_byte({4'h0, cs[4*i +: 4]});
        v = v0;
        for (int i = 0; i < r; i++) begin
            c = int'(cs[4*i +: 4]);
            for (int j = 0; j < c; j++) begin
                put_byte(v);
                e.d  = v;
                e.ce = (j == c - 1);
                e.re = (j == c - 1) && (i == r - 1);
                exp_q.push_back(e);
                v = v + 8'(step);
            end
        end
    endtask

    task automatic pulse_start(input logic [15:0] base);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_no_timeout"}, 32'(n < 5000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_got(input int k);
        int n = 0;
        while (got_q.size() < k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_got_no_timeout", 32'(n < 3000), 32'd1);
    endtask

    task automatic cmp_stream(input string name);
        chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) chk({name, "_elem"}, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    vec_t t1 [16];

    initial begin
        int d0;
        int k;
        logic [7:0] hold_v;

        // Expected stream of the 2x3, 3x2, 2x2 job.
        t1[0]  = '{8'hA0, 1'b0, 1'b0}; t1[1]  = '{8'hA1, 1'b0, 1'b0};
        t1[2]  = '{8'hA2, 1'b1, 1'b0}; t1[3]  = '{8'hA3, 1'b0, 1'b0};
        t1[4]  = '{8'hA4, 1'b0, 1'b0}; t1[5]  = '{8'hA5, 1'b1, 1'b1};
        t1[6]  = '{8'hB0, 1'b0, 1'b0}; t1[7]  = '{8'hB1, 1'b1, 1'b0};
        t1[8]  = '{8'hB2, 1'b0, 1'b0}; t1[9]  = '{8'hB3, 1'b1, 1'b0};
        t1[10] = '{8'hB4, 1'b0, 1'b0}; t1[11] = '{8'hB5, 1'b1, 1'b1};
        t1[12] = '{8'hC0, 1'b0, 1'b0}; t1[13] = '{8'hC1, 1'b1, 1'b0};
        t1[14] = '{8'hC2, 1'b0, 1'b0}; t1[15] = '{8'hC3, 1'b1, 1'b1};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst = 1'b1; start = 1'b0; busy = 1'b0; base_addr = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({feed_vld, in_data, col_end, row_end, done, err, mem_rd, mem_addr}), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_outputs", 32'({feed_vld, done, mem_rd}), 32'd0);

        // Job 1: nominal shapes, MM busy during the first gap, stray start mid-job.
        wp = 16'h0100;
        put_mx(2, 60'h33, 8'hA0, 1);
        put_mx(3, 60'h222, 8'hB0, 1);
        put_mx(2, 60'h22, 8'hC0, 1);
        got_q.delete(); d0 = done_cnt;
        fork
            begin
                pulse_start(16'h0100);
                wait_done(d0, "t1");
            end
            begin
                wait_got(3);
                @(posedge clk); #1; start = 1'b1; base_addr = 16'h0700;
                @(posedge clk); #1; start = 1'b0;
                wait_got(6);
                @(posedge clk); #1; busy = 1'b1;
                repeat (4) @(posedge clk);
                #1; busy = 1'b0;
            end
        join
        chk("t1_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk("t1_elem", 32'(got_q[i]), 32'({t1[i].d, t1[i].ce, t1[i].re}));
        chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
        chk("t1_err", 32'(last_err), 32'd0);

        // Job 2: ragged first matrix C={1,3}.
        wp = 16'h0200; exp_q.delete();
        put_mx(2, 60'h31, 8'hD0, 1);
        put_mx(1, 60'h2, 8'hD4, 1);
        put_mx(1, 60'h1, 8'hD6, 1);
        got_q.delete(); d0 = done_cnt;
        pulse_start(16'h0200);
        wait_done(d0, "t2");
        chk("t2_e1_ce_re", 32'(got_q[0][1:0]), 32'd2);
        chk("t2_e2_ce_re", 32'(got_q[1][1:0]), 32'd0);
        chk("t2_e3_ce_re", 32'(got_q[2][1:0]), 32'd0);
        chk("t2_e4_ce_re", 32'(got_q[3][1:0]), 32'd3);
        cmp_stream("t2");

        // Job 3: 5-cycle stall mid-row.
        wp = 16'h0300; exp_q.delete();
        put_mx(3, 60'h444, 8'h40, 3);
        put_mx(2, 60'h33, 8'h70, 1);
        put_mx(1, 60'h5, 8'h80, 1);
        got_q.delete(); d0 = done_cnt; fifo_max = 0;
        pulse_start(16'h0300);
        wait_got(5);
        @(posedge clk); #1; busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            k = got_q.size();
            hold_v = exp_q[k].d;
            chk("t3_stall_vld", 32'(feed_vld), 32'd1);
            chk("t3_stall_data", 32'(in_data), 32'(hold_v));
        end
        @(posedge clk); #1; busy = 1'b0;
        wait_done(d0, "t3");
        cmp_stream("t3");
        chk("t3_fifo_le2", 32'(fifo_max <= 2), 32'd1);

        // Job 4: second matrix header R=0 aborts with err.
        wp = 16'h0400; exp_q.delete();
        put_mx(2, 60'h22, 8'h90, 1);
        put_byte(8'h00);
        got_q.delete(); d0 = done_cnt;
        pulse_start(16'h0400);
        k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("t4_done_seen", 32'({done, err}), 32'd3);
        @(negedge clk);
        chk("t4_idle_after", 32'({done, feed_vld, mem_rd}), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_quiet", 32'({feed_vld, mem_rd}), 32'd0);
        cmp_stream("t4");

        // Job 5: reset mid-stream, then a fresh job.
        wp = 16'h0500; exp_q.delete();
        put_mx(3, 60'h333, 8'h10, 1);
        put_mx(1, 60'h1, 8'h20, 1);
        put_mx(1, 60'h1, 8'h21, 1);
        got_q.delete(); d0 = done_cnt;
        pulse_start(16'h0500);
        wait_got(3);
        @(posedge clk); #1; rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_reset_outputs", 32'({feed_vld, in_data, col_end, row_end, done, err, mem_rd}), 32'd0);
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        wp = 16'h0600; exp_q.delete();
        put_mx(2, 60'h45, 8'h60, 1);
        put_mx(1, 60'h3, 8'h6B, 1);
        put_mx(2, 60'h12, 8'h6E, 1);
        got_q.delete(); d0 = done_cnt;
        pulse_start(16'h0600);
        wait_done(d0, "t5");
        cmp_stream("t5");
        chk("t5_err", 32'(last_err), 32'd0);

        // Job 6: job straddling the top of the address space.
        wp = 16'hFFFE; exp_q.delete();
        put_mx(1, 60'h3, 8'hE0, 1);
        put_mx(1, 60'h2, 8'hE3, 1);
        put_mx(2, 60'h11, 8'hE5, 1);
        got_q.delete(); d0 = done_cnt;
        pulse_start(16'hFFFE);
        wait_done(d0, "t6");
        cmp_stream("t6");

`ifdef FEED_CHECKSUM_EN
        // Job 7: 300 elements of 0xFF.
        wp = 16'h1000; exp_q.delete();
        put_mx(15, 60'hFFFFFFFFFFFFFFF, 8'hFF, 0);
        put_mx(4, 60'hFFFF, 8'hFF, 0);
        put_mx(1, 60'hF, 8'hFF, 0);
        got_q.delete(); d0 = done_cnt;
        pulse_start(16'h1000);
        wait_done(d0, "t7");
        chk("t7_count", 32'(got_q.size()), 32'd300);
        chk("t7_csum", 32'(csum), 32'h2AD4);
        repeat (3) @(negedge clk);
        chk("t7_csum_hold", 32'(csum), 32'h2AD4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
